// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between the instruction-fetch
// path (IF) and the data load/store path (DM).
//
// Each transaction runs through four phases: IDLE (arbitrate), ISSUE (one-cycle memory
// strobe), WAIT (MEM_LAT cycles) and DONE (one-cycle done pulse to the winner).
//
// Ports:
//   CLK, RST              clock; synchronous active-high reset
//   if_req/if_addr        IF read request, held until if_done
//   if_done/if_rdata      IF completion pulse and registered read data
//   if_stall              if_req & ~if_done
//   dm_req/dm_we/dm_addr/dm_wdata  DM request, held until dm_done
//   dm_done/dm_rdata      DM completion pulse and registered read data
//   dm_stall              dm_req & ~dm_done
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                  a transaction is in progress
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [2:0] MaxWait = 3'(MAX_WAIT);
  localparam logic [3:0] MemLat  = 4'(MEM_LAT);

  state_e              state_q, state_d;
  logic [2:0]          if_wait_q, if_wait_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic                sel_dm_q, sel_dm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic                grant_if;

  always_comb begin
    state_d    = state_q;
    if_wait_d  = if_wait_q;
    lat_cnt_d  = lat_cnt_q;
    sel_dm_d   = sel_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    grant_if   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_req || dm_req) begin
          // DM has priority unless IF has already lost MAX_WAIT arbitrations in a row.
          grant_if = if_req && (!dm_req || (if_wait_q == MaxWait));
          sel_dm_d = !grant_if;
          addr_d   = grant_if ? if_addr : dm_addr;
          we_d     = grant_if ? 1'b0 : dm_we;
          // IF never writes, so mem_wdata keeps its previous value on IF grants.
          wdata_d  = grant_if ? wdata_q : dm_wdata;
          if (grant_if) begin
            if_wait_d = 3'd0;
          end else if (if_req && (if_wait_q != MaxWait)) begin
            if_wait_d = if_wait_q + 3'd1;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        lat_cnt_d = MemLat;
        state_d   = StWait;
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          if (!we_q) begin
            if (sel_dm_q) dm_rdata_d = mem_rdata;
            else          if_rdata_d = mem_rdata;
          end
          if (sel_dm_q) dm_done_d = 1'b1;
          else          if_done_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      if_wait_q  <= 3'd0;
      lat_cnt_q  <= 4'd0;
      sel_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_wait_q  <= if_wait_d;
      lat_cnt_q  <= lat_cnt_d;
      sel_dm_q   <= sel_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
    end
  end

  // The strobe is tied to the ISSUE state, so mem_we drops as soon as ISSUE is left.
  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req && !if_done_q;
  assign dm_stall  = dm_req && !dm_done_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned LAT  = 1;
  localparam int unsigned LAT3 = 3;
  localparam int unsigned MAXW = 3;

  logic        CLK = 1'b0;
  logic        RST;
  // Main DUT (MEM_LAT = 1)
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  // Second DUT (MEM_LAT = 3)
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic        b_if_done, b_if_stall, b_dm_done, b_dm_stall, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;

  int tests = 0;
  int fails = 0;

  // Reference state: lost arbitrations of IF, expected held read data, memory shadow.
  int          losses = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  bit   [31:0] shadow    [256];
  bit          shadow_wr [256];

  // Memory model contents and an override used by directed tests.
  bit   [31:0] mem_arr [256];
  bit          written [256];
  bit          ovr_en  = 1'b0;
  bit   [31:0] ovr_val = '0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_WAIT(MAXW)) u_dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT3), .MAX_WAIT(MAXW)) u_dut3 (
    .CLK(CLK), .RST(RST),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .if_stall(b_if_stall),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_done(b_dm_done), .dm_rdata(b_dm_rdata), .dm_stall(b_dm_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] init_val(logic [7:0] i);
    return {4{i}} ^ 32'hA5C3_0F69;
  endfunction

  function automatic logic [31:0] exp_mem(logic [31:0] a);
    return shadow_wr[a[7:0]] ? shadow[a[7:0]] : init_val(a[7:0]);
  endfunction

  // Synchronous memory with MEM_LAT = 1: read data is valid only in the cycle after mem_en.
  always @(posedge CLK) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      written[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= ovr_en ? ovr_val :
                   (written[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]] : init_val(mem_addr[7:0]));
    end else begin
      mem_rdata <= $urandom;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    b_if_req = 0; b_dm_req = 0; b_dm_we = 0; b_if_addr = '0; b_dm_addr = '0;
    b_dm_wdata = '0; b_mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      tick();
    end
    RST = 1'b0;
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    #1;
    tests++;
    if ({if_done, dm_done, mem_en, mem_we, busy, if_stall, dm_stall} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {if_done, dm_done, mem_en, mem_we, busy, if_stall, dm_stall});
    end
    tests++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: got %h %h %h %h want all 0",
               mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    tests++;
    if ({b_busy, b_mem_en, b_if_done, b_dm_done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_lat3: got %b want 0000", {b_busy, b_mem_en, b_if_done, b_dm_done});
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    losses = 0; exp_if_rdata = '0; exp_dm_rdata = '0;
  endtask

  task automatic test_if_read();
    ovr_en = 1'b1; ovr_val = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (dm_done !== 1'b0) begin
        fails++;
        $display("FAIL ifrd_dm_done c%0d: got %b want 0", c, dm_done);
      end
      if (c == 1) begin
        tests++;
        if ({mem_en, mem_we, mem_addr, if_stall} !== {1'b1, 1'b0, 32'h10, 1'b1}) begin
          fails++;
          $display("FAIL ifrd_issue: en=%b we=%b addr=%h stall=%b want 1 0 00000010 1",
                   mem_en, mem_we, mem_addr, if_stall);
        end
      end
      if (c == 3) begin
        tests++;
        if ({if_done, if_rdata, if_stall} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
          fails++;
          $display("FAIL ifrd_done: done=%b rdata=%h stall=%b want 1 deadbeef 0",
                   if_done, if_rdata, if_stall);
        end
        if_req = 1'b0;
      end else begin
        tests++;
        if (if_done !== 1'b0) begin
          fails++;
          $display("FAIL ifrd_early c%0d: if_done=%b want 0", c, if_done);
        end
      end
    end
    tick();
    tests++;
    if ({busy, if_done} !== 2'b00) begin
      fails++;
      $display("FAIL ifrd_after: busy=%b done=%b want 0 0", busy, if_done);
    end
    ovr_en = 1'b0; exp_if_rdata = 32'hDEADBEEF; losses = 0;
  endtask

  task automatic test_dm_write();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h12345678;
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (if_done !== 1'b0) begin
        fails++;
        $display("FAIL dmwr_if_done c%0d: got %b want 0", c, if_done);
      end
      if (c == 1) begin
        tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h12345678}) begin
          fails++;
          $display("FAIL dmwr_issue: en=%b we=%b addr=%h wdata=%h want 1 1 00000020 12345678",
                   mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (c == 2) begin
        tests++;
        if ({mem_en, mem_we, dm_done} !== 3'b000) begin
          fails++;
          $display("FAIL dmwr_wait: en=%b we=%b done=%b want 000", mem_en, mem_we, dm_done);
        end
      end
      if (c == 3) begin
        tests++;
        if ({dm_done, dm_rdata} !== {1'b1, exp_dm_rdata}) begin
          fails++;
          $display("FAIL dmwr_done: done=%b rdata=%h want 1 %h", dm_done, dm_rdata, exp_dm_rdata);
        end
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end
    shadow[8'h20] = 32'h12345678; shadow_wr[8'h20] = 1'b1;
    tick();
  endtask

  task automatic test_arbitration();
    int n = 0;
    bit exp_if_win, done_now;
    if_req = 1'b1; if_addr = 32'($urandom_range(0, 255));
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'($urandom_range(0, 255));
    // Both always present: grant k happens in cycle k*(3+LAT), done 2+LAT cycles later.
    for (int cyc = 1; cyc <= 40 && n < 8; cyc++) begin
      tick();
      exp_if_win = (losses == MAXW);
      done_now = (cyc == n * (3 + LAT) + 2 + LAT);
      tests++;
      if ({if_done, dm_done} !== {done_now && exp_if_win, done_now && !exp_if_win}) begin
        fails++;
        $display("FAIL arb_order cyc%0d grant%0d: if_done=%b dm_done=%b want %b %b", cyc, n,
                 if_done, dm_done, done_now && exp_if_win, done_now && !exp_if_win);
      end
      tests++;
      if (if_stall !== !(done_now && exp_if_win)) begin
        fails++;
        $display("FAIL arb_if_stall cyc%0d: got %b want %b", cyc, if_stall,
                 !(done_now && exp_if_win));
      end
      if (done_now) begin
        if (exp_if_win) begin
          exp_if_rdata = exp_mem(if_addr);
          tests++;
          if (if_rdata !== exp_if_rdata) begin
            fails++;
            $display("FAIL arb_if_rdata: got %h want %h", if_rdata, exp_if_rdata);
          end
          if_addr = 32'($urandom_range(0, 255));
          losses = 0;
        end else begin
          exp_dm_rdata = exp_mem(dm_addr);
          tests++;
          if (dm_rdata !== exp_dm_rdata) begin
            fails++;
            $display("FAIL arb_dm_rdata: got %h want %h", dm_rdata, exp_dm_rdata);
          end
          dm_addr = 32'($urandom_range(0, 255));
          if (losses < MAXW) losses++;
        end
        n++;
        // The arbiter ignores requests in DONE, so withdrawing both here is clean.
        if (n == 8) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL arb_count: got %0d grants want 8", n);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'($urandom_range(0, 255));
    tick();
    tick();
    RST = 1'b1; dm_req = 1'b0;
    tick();
    RST = 1'b0;
    losses = 0; exp_if_rdata = '0; exp_dm_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({dm_done, busy, dm_rdata} !== {1'b0, 1'b0, 32'h0}) begin
        fails++;
        $display("FAIL abort_quiet c%0d: done=%b busy=%b rdata=%h want 0 0 0",
                 c, dm_done, busy, dm_rdata);
      end
      tick();
    end
    dm_req = 1'b1; dm_addr = 32'($urandom_range(0, 255));
    for (int c = 1; c <= 3; c++) begin
      tick();
      tests++;
      if (dm_done !== (c == 3)) begin
        fails++;
        $display("FAIL abort_retry c%0d: dm_done=%b want %b", c, dm_done, c == 3);
      end
    end
    exp_dm_rdata = exp_mem(dm_addr);
    tests++;
    if (dm_rdata !== exp_dm_rdata) begin
      fails++;
      $display("FAIL abort_rdata: got %h want %h", dm_rdata, exp_dm_rdata);
    end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_lat3();
    b_if_req = 1'b1; b_if_addr = 32'h40;
    for (int c = 1; c <= 5; c++) begin
      tick();
      b_mem_rdata = (c == 4) ? 32'hCAFEF00D : $urandom;
      if (c == 1) begin
        tests++;
        if ({b_mem_en, b_mem_we, b_mem_addr} !== {1'b1, 1'b0, 32'h40}) begin
          fails++;
          $display("FAIL lat3_issue: en=%b we=%b addr=%h want 1 0 00000040",
                   b_mem_en, b_mem_we, b_mem_addr);
        end
      end
      if (c < 5) begin
        tests++;
        if (b_if_done !== 1'b0) begin
          fails++;
          $display("FAIL lat3_early c%0d: if_done=%b want 0", c, b_if_done);
        end
      end else begin
        tests++;
        if ({b_if_done, b_if_rdata} !== {1'b1, 32'hCAFEF00D}) begin
          fails++;
          $display("FAIL lat3_done: done=%b rdata=%h want 1 cafef00d", b_if_done, b_if_rdata);
        end
        b_if_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_random();
    int free_at = 0, if_exp = -1, dm_exp = -1, grant_cyc = -10;
    bit g_if = 0, g_we = 0, if_dn, dm_dn;
    logic [31:0] g_addr = '0, g_wdata = '0;
    if_req = 1'b0; dm_req = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      tick();
      if_dn = (cyc == if_exp);
      dm_dn = (cyc == dm_exp);
      tests++;
      if ({if_done, dm_done} !== {if_dn, dm_dn}) begin
        fails++;
        $display("FAIL rnd_done cyc%0d: if=%b dm=%b want %b %b",
                 cyc, if_done, dm_done, if_dn, dm_dn);
      end
      if (if_dn) begin
        exp_if_rdata = exp_mem(g_addr);
        if_req = 1'b0; if_exp = -1;
      end
      if (dm_dn) begin
        if (g_we) begin
          shadow[g_addr[7:0]] = g_wdata; shadow_wr[g_addr[7:0]] = 1'b1;
        end else begin
          exp_dm_rdata = exp_mem(g_addr);
        end
        dm_req = 1'b0; dm_exp = -1;
      end
      tests++;
      if ({if_rdata, dm_rdata} !== {exp_if_rdata, exp_dm_rdata}) begin
        fails++;
        $display("FAIL rnd_rdata cyc%0d: if=%h dm=%h want %h %h",
                 cyc, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
      end
      tests++;
      if (cyc == grant_cyc + 1) begin
        if ({mem_en, mem_we, mem_addr} !== {1'b1, g_we, g_addr} ||
            (g_we && mem_wdata !== g_wdata)) begin
          fails++;
          $display("FAIL rnd_issue cyc%0d: en=%b we=%b addr=%h wd=%h want 1 %b %h %h",
                   cyc, mem_en, mem_we, mem_addr, mem_wdata, g_we, g_addr, g_wdata);
        end
      end else if ({mem_en, mem_we} !== 2'b00) begin
        fails++;
        $display("FAIL rnd_mem_en cyc%0d: en=%b we=%b want 0 0", cyc, mem_en, mem_we);
      end
      if (cyc < 380) begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 32'($urandom_range(0, 15)) << 2;
        end
        if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom); dm_wdata = $urandom;
          dm_addr = 32'($urandom_range(0, 15)) << 2;
        end
      end
      #1;
      tests++;
      if ({if_stall, dm_stall} !== {if_req && !if_dn, dm_req && !dm_dn}) begin
        fails++;
        $display("FAIL rnd_stall cyc%0d: if=%b dm=%b want %b %b", cyc, if_stall, dm_stall,
                 if_req && !if_dn, dm_req && !dm_dn);
      end
      // A new transaction starts whenever the arbiter is free and someone is asking.
      if (cyc >= free_at && (if_req || dm_req)) begin
        g_if = if_req && (!dm_req || losses == MAXW);
        if (g_if) losses = 0;
        else if (if_req && losses < MAXW) losses++;
        g_addr  = g_if ? if_addr : dm_addr;
        g_we    = g_if ? 1'b0 : dm_we;
        g_wdata = dm_wdata;
        grant_cyc = cyc;
        free_at = cyc + 3 + LAT;
        if (g_if) if_exp = cyc + 2 + LAT;
        else      dm_exp = cyc + 2 + LAT;
      end
    end
    tests++;
    if ({busy, if_req, dm_req} !== 3'b000) begin
      fails++;
      $display("FAIL rnd_drain: busy=%b if_req=%b dm_req=%b want 000", busy, if_req, dm_req);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write();
    test_arbitration();
    test_reset_abort();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
